activation_sequencer: RTL and testbench
=======================================

// Module: activation_sequencer
// PURPOSE
//  Sequences the per-engine activation stage for one layer at a time.
//  - Accepts a layer config: activation function code and batch count.
//  - Admits that many batches from the MAC/accumulator stage.
//  - Drives the activation stage's enable and function select.
//  - Emits an output-valid pulse when each batch's activated result is on the activation outputs.
//  - Sits between the layer scheduler (config side), the accumulator (source side)
//    and the writeback buffer (destination side).
// PARAMETERS
//  BatchW   16  width of the batch count and counters
//  LatNone  1   activation-stage latency (cycles, issue->data visible) for fn code 0 (None)
//  LatRelu  2   activation-stage latency for fn code 1 (ReLU); an extra internal register stage
// PORTS
//  clk_i          in   1       clock; single clock domain
//  rst_i          in   1       synchronous, active-high reset
//  cfg_valid_i    in   1       layer config offered
//  cfg_ready_o    out  1       high only in IDLE
//  cfg_fn_i       in   3       activation function code: 0=None, 1=ReLU, others reserved
//  cfg_batches_i  in   BatchW  number of batches in the layer
//  src_valid_i    in   1       accumulator batch present on activation inputs
//  src_ready_o    out  1       batch issued this cycle when src_valid_i && src_ready_o
//  dst_ready_i    in   1       writeback guarantees it accepts a pulse issued now, L cycles later
//  dst_valid_o    out  1       activated batch valid on activation outputs this cycle (1-cycle pulse)
//  act_en_o       out  1       enable to activation stage
//  act_fn_o       out  3       function select to activation stage; stable for the whole layer
//  busy_o         out  1       state != IDLE
//  done_o         out  1       1-cycle pulse: layer complete, all results delivered
//  cfg_err_o      out  1       sticky: reserved fn code seen; cleared on next accepted config
// BEHAVIOUR
//  Reset (rst_i=1 at an edge), including mid-layer:
//  - state=IDLE; counters and in-flight pipe cleared.
//  - act_en_o=0, act_fn_o=0, dst_valid_o=0, done_o=0, cfg_err_o=0.
//  - In-flight batches are dropped; no dst_valid_o is emitted for them.
//  States:
//  - IDLE: cfg_ready_o=1. On cfg_valid_i, latch fn and total, clear issued count, -> RUN.
//    Reserved fn code: latch fn=0 (pass-through) and set cfg_err_o.
//  - RUN: src_ready_o = (issued < total) && dst_ready_i.
//    Each handshake increments issued and pushes a token into the in-flight pipe.
//    When issued==total (incl. total==0 on entry), -> DRAIN.
//  - DRAIN: wait until the in-flight pipe is empty, then -> DONE.
//  - DONE: done_o=1 for exactly one cycle; -> IDLE.
//  Latency: L = LatRelu if latched fn==1, else LatNone; fixed per layer.
//  - A batch issued in cycle t produces dst_valid_o=1 in cycle t+L exactly.
//  act_en_o = issue_this_cycle | token pending in cycles t+1..t+L-1.
//  - Must be high for every cycle t..t+L-1 of every in-flight batch;
//    the activation stage zeroes its outputs when the enable is low.
//  Pipelining:
//  - Back-to-back issue is allowed; one batch per cycle max.
//  - Each token is carried in an L-deep shift register; no token is merged or lost.
//  dst_valid_o is never asserted outside RUN/DRAIN, and never in the cycle of done_o.
//  Counters: issued and total are BatchW bits; issued never exceeds total, so no wrap.
//  act_fn_o updates only on config accept; holds its value through DONE and IDLE until the next config.
//  cfg_valid_i is ignored outside IDLE. src_valid_i is ignored outside RUN.
// TESTING
//  1 ReLU, 3 batches, src_valid_i/dst_ready_i held high:
//    src_ready_o handshakes at t, t+1, t+2; dst_valid_o at t+2, t+3, t+4;
//    act_en_o high t..t+3; done_o at t+6 (DRAIN t+3..t+5, DONE t+6).
//  2 None, 2 batches: dst_valid_o exactly 1 cycle after each issue;
//    act_en_o low except on issue cycles.
//  3 cfg_batches_i=0, fn=1: RUN->DRAIN->DONE with no src_ready_o or dst_valid_o;
//    done_o 3 cycles after the config handshake.
//  4 dst_ready_i toggled 1,0,0,1 with src_valid_i=1, ReLU:
//    issues only on ready cycles; dst_valid_o 2 cycles after each issue; count ends at 2.
//  5 fn=5: cfg_err_o=1, act_fn_o=0, latency 1; next config with fn=1 clears cfg_err_o.
//  6 rst_i pulsed one cycle after 2nd ReLU issue:
//    next cycle IDLE, act_en_o=0, no dst_valid_o, cfg_ready_o=1.

Source files
------------

// File: rtl/activation_sequencer.sv
// Per-layer activation-stage sequencer: admits a configured number of batches,
// drives the activation enable/function select and times the output-valid pulses.
module activation_sequencer #(
    parameter int BatchW  = 16,
    parameter int LatNone = 1,
    parameter int LatRelu = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [2:0]        cfg_fn_i,
    input  logic [BatchW-1:0] cfg_batches_i,
    input  logic              src_valid_i,
    output logic              src_ready_o,
    input  logic              dst_ready_i,
    output logic              dst_valid_o,
    output logic              act_en_o,
    output logic [2:0]        act_fn_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
);

    localparam int LatMax = (LatRelu > LatNone) ? LatRelu : LatNone;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [BatchW-1:0]   total_q;
    logic [BatchW-1:0]   issued_q;
    logic [BatchW-1:0]   issued_d;
    logic [2:0]          fn_q;
    logic                relu_q;
    logic                err_q;
    logic [LatMax-1:0]   pipe_q;
    logic [LatMax-1:0]   pipe_d;
    logic [LatMax-1:0]   live_mask;
    logic [LatMax-1:0]   pend_mask;
    logic                issue;
    int                  lat;

    assign lat = relu_q ? LatRelu : LatNone;

    // Token in pipe bit k was issued k+1 cycles ago; bits at or beyond L are never populated.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        live_mask = '0;
        pend_mask = '0;
        for (int i = 0; i < LatMax; i++) begin
            live_mask[i] = (i < lat);
            pend_mask[i] = (i < lat - 1);
        end
        pipe_d    = '0;
        pipe_d[0] = issue;
        for (int i = 1; i < LatMax; i++) begin
            pipe_d[i] = pipe_q[i-1] & live_mask[i];
        end
    end

    assign src_ready_o = (state_q == S_RUN) && (issued_q < total_q) && dst_ready_i;
    assign issue       = src_valid_i && src_ready_o;
    assign issued_d    = issued_q + {{(BatchW-1){1'b0}}, issue};

    assign cfg_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign act_en_o    = issue | (|(pipe_q & pend_mask));
    assign dst_valid_o = |(pipe_q & live_mask & ~pend_mask);
    assign act_fn_o    = fn_q;
    assign cfg_err_o   = err_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            total_q  <= '0;
            issued_q <= '0;
            fn_q     <= 3'd0;
            relu_q   <= 1'b0;
            err_q    <= 1'b0;
            pipe_q   <= '0;
        end else begin
            pipe_q <= pipe_d;
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid_i) begin
                        total_q  <= cfg_batches_i;
                        issued_q <= '0;
                        if (cfg_fn_i <= 3'd1) begin
                            fn_q   <= cfg_fn_i;
                            relu_q <= (cfg_fn_i == 3'd1);
                            err_q  <= 1'b0;
                        end else begin
                            fn_q   <= 3'd0;
                            relu_q <= 1'b0;
                            err_q  <= 1'b1;
                        end
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    issued_q <= issued_d;
                    // Leave on the cycle the last batch issues so DRAIN starts right after it.
                    if (issued_d == total_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pipe_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_activation_sequencer.sv
// Directed bench for activation_sequencer: cycle-exact output traces per layer scenario.
module tb_activation_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [2:0]  cfg_fn_i;
    logic [15:0] cfg_batches_i;
    logic        src_valid_i;
    logic        src_ready_o;
    logic        dst_ready_i;
    logic        dst_valid_o;
    logic        act_en_o;
    logic [2:0]  act_fn_o;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] rv_srdy, rv_dv, rv_en, rv_done;

    activation_sequencer #(.BatchW(16), .LatNone(1), .LatRelu(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_fn_i      (cfg_fn_i),
        .cfg_batches_i (cfg_batches_i),
        .src_valid_i   (src_valid_i),
        .src_ready_o   (src_ready_o),
        .dst_ready_i   (dst_ready_i),
        .dst_valid_o   (dst_valid_o),
        .act_en_o      (act_en_o),
        .act_fn_o      (act_fn_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cfg_err_o     (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Offer a config for one cycle; returns #1 after the accepting edge.
    task automatic apply_cfg(input logic [2:0] fn, input logic [15:0] n);
        cfg_valid_i   = 1'b1;
        cfg_fn_i      = fn;
        cfg_batches_i = n;
        @(posedge clk_i); #1;
        cfg_valid_i   = 1'b0;
    endtask

    // Record n cycles of outputs (bit i = cycle i), driving dst_ready_i from a pattern.
    task automatic record(input int n, input logic [15:0] drdy);
        rv_srdy = '0; rv_dv = '0; rv_en = '0; rv_done = '0;
        for (int i = 0; i < n; i++) begin
            dst_ready_i = drdy[i];
            #1;
            rv_srdy[i] = src_ready_o;
            rv_dv[i]   = dst_valid_o;
            rv_en[i]   = act_en_o;
            rv_done[i] = done_o;
            @(posedge clk_i); #1;
        end
        dst_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({cfg_ready_o, busy_o, act_en_o, dst_valid_o, done_o, cfg_err_o, src_ready_o} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 1000000", {cfg_ready_o, busy_o, act_en_o, dst_valid_o, done_o, cfg_err_o, src_ready_o});
        end
        n_cmp++;
        if (act_fn_o !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_fn: got %0d want 0", act_fn_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_relu_back_to_back();
        src_valid_i = 1'b1;
        dst_ready_i = 1'b1;
        n_cmp++;
        if (cfg_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL relu_cfg_ready: got %b want 1", cfg_ready_o);
        end
        apply_cfg(3'd1, 16'd3);
        record(8, 16'hFFFF);
        n_cmp++;
        if (rv_srdy !== 16'h0007) begin n_bad++; $display("FAIL relu_issue: got %h want 0007", rv_srdy); end
        n_cmp++;
        if (rv_dv !== 16'h001C) begin n_bad++; $display("FAIL relu_dst_valid: got %h want 001c", rv_dv); end
        n_cmp++;
        if (rv_en !== 16'h000F) begin n_bad++; $display("FAIL relu_act_en: got %h want 000f", rv_en); end
        n_cmp++;
        if (rv_done !== 16'h0040) begin n_bad++; $display("FAIL relu_done: got %h want 0040", rv_done); end
        n_cmp++;
        if ({busy_o, cfg_ready_o, act_fn_o} !== 5'b01001) begin
            n_bad++;
            $display("FAIL relu_idle_after: got %b want 01001", {busy_o, cfg_ready_o, act_fn_o});
        end
        src_valid_i = 1'b0;
    endtask

    task automatic test_none();
        src_valid_i = 1'b1;
        apply_cfg(3'd0, 16'd2);
        record(8, 16'hFFFF);
        n_cmp++;
        if (rv_srdy !== 16'h0003) begin n_bad++; $display("FAIL none_issue: got %h want 0003", rv_srdy); end
        n_cmp++;
        if (rv_dv !== 16'h0006) begin n_bad++; $display("FAIL none_dst_valid: got %h want 0006", rv_dv); end
        n_cmp++;
        if (rv_en !== 16'h0003) begin n_bad++; $display("FAIL none_act_en: got %h want 0003", rv_en); end
        n_cmp++;
        if (rv_done !== 16'h0010) begin n_bad++; $display("FAIL none_done: got %h want 0010", rv_done); end
        src_valid_i = 1'b0;
    endtask

    task automatic test_zero_batches();
        src_valid_i = 1'b1;
        apply_cfg(3'd1, 16'd0);
        record(6, 16'hFFFF);
        n_cmp++;
        if ({rv_srdy, rv_dv, rv_en} !== 48'h0) begin
            n_bad++;
            $display("FAIL zero_no_traffic: srdy %h dv %h en %h want all 0000", rv_srdy, rv_dv, rv_en);
        end
        n_cmp++;
        if (rv_done !== 16'h0004) begin n_bad++; $display("FAIL zero_done: got %h want 0004", rv_done); end
        src_valid_i = 1'b0;
    endtask

    task automatic test_backpressure();
        src_valid_i = 1'b1;
        apply_cfg(3'd1, 16'd2);
        record(10, 16'hFFF9);
        n_cmp++;
        if (rv_srdy !== 16'h0009) begin n_bad++; $display("FAIL bp_issue: got %h want 0009", rv_srdy); end
        n_cmp++;
        if ($countones(rv_srdy) != 2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", $countones(rv_srdy)); end
        n_cmp++;
        if (rv_dv !== 16'h0024) begin n_bad++; $display("FAIL bp_dst_valid: got %h want 0024", rv_dv); end
        n_cmp++;
        if (rv_en !== 16'h001B) begin n_bad++; $display("FAIL bp_act_en: got %h want 001b", rv_en); end
        n_cmp++;
        if (rv_done !== 16'h0080) begin n_bad++; $display("FAIL bp_done: got %h want 0080", rv_done); end
        src_valid_i = 1'b0;
    endtask

    task automatic test_reserved_fn();
        src_valid_i = 1'b1;
        apply_cfg(3'd5, 16'd1);
        n_cmp++;
        if ({cfg_err_o, act_fn_o} !== 4'b1000) begin
            n_bad++;
            $display("FAIL rsv_err_fn: got %b want 1000", {cfg_err_o, act_fn_o});
        end
        record(5, 16'hFFFF);
        n_cmp++;
        if (rv_dv !== 16'h0002) begin n_bad++; $display("FAIL rsv_latency: got %h want 0002", rv_dv); end
        n_cmp++;
        if (rv_done !== 16'h0008) begin n_bad++; $display("FAIL rsv_done: got %h want 0008", rv_done); end
        n_cmp++;
        if (cfg_err_o !== 1'b1) begin n_bad++; $display("FAIL rsv_sticky: got %b want 1", cfg_err_o); end
        apply_cfg(3'd1, 16'd0);
        n_cmp++;
        if ({cfg_err_o, act_fn_o} !== 4'b0001) begin
            n_bad++;
            $display("FAIL rsv_clear: got %b want 0001", {cfg_err_o, act_fn_o});
        end
        src_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_mid_reset();
        int dv_seen;
        src_valid_i = 1'b1;
        apply_cfg(3'd1, 16'd4);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i       = 1'b1;
        src_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_cmp++;
        if ({busy_o, cfg_ready_o, act_en_o, dst_valid_o, done_o, act_fn_o} !== 8'b01000000) begin
            n_bad++;
            $display("FAIL mreset_state: got %b want 01000000", {busy_o, cfg_ready_o, act_en_o, dst_valid_o, done_o, act_fn_o});
        end
        dv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (dst_valid_o === 1'b1) dv_seen++;
            @(posedge clk_i); #1;
        end
        n_cmp++;
        if (dv_seen != 0) begin n_bad++; $display("FAIL mreset_no_dv: got %0d pulses want 0", dv_seen); end
    endtask

    initial begin
        rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_fn_i = 3'd0; cfg_batches_i = '0;
        src_valid_i = 1'b0; dst_ready_i = 1'b1;
        test_reset();
        test_relu_back_to_back();
        test_none();
        test_zero_batches();
        test_backpressure();
        test_reserved_fn();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
